// File: rtl/instr_fetch_pkg.sv
// Shared types and sizing for the instruction fetch front end.
package instr_fetch_pkg;

    localparam int unsigned N_BLOCKS    = 256;
    localparam int unsigned INSTR_WIDTH = 32;
    localparam int unsigned PC_W        = $clog2(N_BLOCKS);

    typedef enum logic [1:0] {
        StIdle,
        StFetch,
        StDrain
    } fetch_state_t;

    typedef struct packed {
        logic                   last;
        logic [PC_W-1:0]        pc;
        logic [INSTR_WIDTH-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_skid_fifo.sv
// Two-entry register FIFO holding tagged instruction words between RAM and decoder.
module fetch_skid_fifo
    import instr_fetch_pkg::*;
(
    input  logic         clk_i,
    input  logic         reset_i,
    input  logic         push_i,
    input  fetch_entry_t data_i,
    input  logic         pop_i,
    output fetch_entry_t data_o,
    output logic [1:0]   occ_o
);

    fetch_entry_t mem_q [2];
    logic         wr_ptr_q, wr_ptr_d;
    logic         rd_ptr_q, rd_ptr_d;
    logic [1:0]   occ_q, occ_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        if (push_i) begin
            wr_ptr_d = ~wr_ptr_q;
        end
        if (pop_i) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        occ_d = occ_q + {1'b0, push_i} - {1'b0, pop_i};
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            occ_q    <= 2'd0;
        end else begin
            if (push_i) begin
                mem_q[wr_ptr_q] <= data_i;
            end
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
        end
    end

    assign data_o = mem_q[rd_ptr_q];
    assign occ_o  = occ_q;

endmodule

// File: rtl/instr_fetch.sv
// Walks the active instruction list per sample tick and streams RAM words to the decoder,
// issuing reads only when a FIFO slot is guaranteed for the returning word.
module instr_fetch
    import instr_fetch_pkg::*;
(
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic                   sample_tick_i,
    input  logic [PC_W:0]          n_blocks_i,
    output logic                   mem_rd_en_o,
    output logic [PC_W-1:0]        mem_addr_o,
    input  logic [INSTR_WIDTH-1:0] mem_rdata_i,
    output logic [INSTR_WIDTH-1:0] instr_o,
    output logic [PC_W-1:0]        instr_pc_o,
    output logic                   instr_last_o,
    output logic                   instr_valid_o,
    input  logic                   instr_ready_i,
    output logic                   busy_o,
    output logic                   pass_done_o,
    output logic                   overrun_o
);

    localparam logic [PC_W:0] One = {{PC_W{1'b0}}, 1'b1};

    fetch_state_t    state_q, state_d;
    logic [PC_W:0]   pc_q, pc_d;
    logic [PC_W:0]   count_q, count_d;
    logic [PC_W-1:0] rd_pc_q, rd_pc_d;
    logic            inflight_q, inflight_d;
    logic            pass_done_q, pass_done_d;
    logic            overrun_q, overrun_d;
    logic            issue, pop;
    logic [1:0]      occ;
    logic [2:0]      credits_used;
    fetch_entry_t    push_entry, head;

    assign pop          = instr_valid_o & instr_ready_i;
    assign credits_used = {1'b0, occ} + {2'b00, inflight_q};

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        count_d     = count_q;
        rd_pc_d     = rd_pc_q;
        pass_done_d = 1'b0;
        overrun_d   = overrun_q;
        issue       = 1'b0;
        mem_addr_o  = '0;
        if (sample_tick_i && (state_q != StIdle)) begin
            overrun_d = 1'b1;
        end
        unique case (state_q)
            StIdle: begin
                if (sample_tick_i) begin
                    if (n_blocks_i == '0) begin
                        pass_done_d = 1'b1;
                    end else begin
                        // Word 0 is read in the tick cycle itself to reach the 2-cycle latency.
                        issue   = 1'b1;
                        count_d = n_blocks_i;
                        pc_d    = One;
                        rd_pc_d = '0;
                        state_d = (n_blocks_i == One) ? StDrain : StFetch;
                    end
                end
            end
            StFetch: begin
                issue = (pc_q < count_q) && (credits_used < (pop ? 3'd3 : 3'd2));
                if (issue) begin
                    mem_addr_o = pc_q[PC_W-1:0];
                    rd_pc_d    = pc_q[PC_W-1:0];
                    pc_d       = pc_q + One;
                    if (pc_d == count_q) begin
                        state_d = StDrain;
                    end
                end
            end
            StDrain: begin
                if (pop && head.last) begin
                    state_d     = StIdle;
                    pass_done_d = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
        inflight_d = issue;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= StIdle;
            pc_q        <= '0;
            count_q     <= '0;
            rd_pc_q     <= '0;
            inflight_q  <= 1'b0;
            pass_done_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            count_q     <= count_d;
            rd_pc_q     <= rd_pc_d;
            inflight_q  <= inflight_d;
            pass_done_q <= pass_done_d;
            overrun_q   <= overrun_d;
        end
    end

    assign push_entry.last  = ({1'b0, rd_pc_q} == (count_q - One));
    assign push_entry.pc    = rd_pc_q;
    assign push_entry.instr = mem_rdata_i;

    fetch_skid_fifo u_fifo (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .push_i  (inflight_q),
        .data_i  (push_entry),
        .pop_i   (pop),
        .data_o  (head),
        .occ_o   (occ)
    );

    assign mem_rd_en_o   = issue & ~reset_i;
    assign instr_o       = head.instr;
    assign instr_pc_o    = head.pc;
    assign instr_last_o  = head.last;
    assign instr_valid_o = (occ != 2'd0);
    assign busy_o        = (state_q != StIdle);
    assign pass_done_o   = pass_done_q;
    assign overrun_o     = overrun_q;

endmodule
